// File: rtl/div_operand_queue.sv
// div_operand_queue
//   Circular operand-pair queue that feeds a 2-bit combinational divider.
//   Each entry is stored as 4 bits {dividend, divisor}.
//   The head entry is driven onto div_a..div_d while the queue is occupied.
//   A dequeue happens when the downstream signals that it consumed the
//   divider result.
//
// Ports
//   clock        single clock; all state changes on its rising edge
//   reset_L      asynchronous active-low reset
//   in_valid     upstream presents {dividend, divisor}
//   in_ready     queue has room; depends only on registered state
//   dividend     dividend bits [1:0]
//   divisor      divisor bits [1:0]
//   out_valid    head entry is presented on div_a..div_d
//   out_ready    downstream consumed the divider result this cycle
//   div_a..div_d head operand bits: dividend[1], dividend[0], divisor[1], divisor[0]
//   div_by_zero  head entry has divisor 2'b00
//   count        number of occupied entries
//   zero_cnt     saturating count of dequeued zero-divisor entries

module div_operand_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_L,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               dividend,
    input  logic [1:0]               divisor,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     div_a,
    output logic                     div_b,
    output logic                     div_c,
    output logic                     div_d,
    output logic                     div_by_zero,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               zero_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Storage is deliberately left out of reset; it is only observed
    // through the head while count is non-zero.
    logic [3:0]    mem_q [DEPTH];
    logic [3:0]    mem_d [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    zero_cnt_q, zero_cnt_d;

    logic          do_enq;
    logic          do_deq;
    logic [3:0]    head;

    // Flow control is derived from count_q alone, so neither in_valid nor
    // out_ready can reach in_ready combinationally. A full queue refuses a
    // write even when a read happens in the same cycle.
    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);

    assign do_enq = in_valid && in_ready;
    assign do_deq = out_valid && out_ready;

    assign head        = mem_q[rd_ptr_q];
    assign div_a       = out_valid & head[3];
    assign div_b       = out_valid & head[2];
    assign div_c       = out_valid & head[1];
    assign div_d       = out_valid & head[0];
    assign div_by_zero = out_valid && (head[1:0] == 2'b00);

    assign count    = count_q;
    assign zero_cnt = zero_cnt_q;

    always_comb begin
        mem_d = mem_q;
        if (do_enq) begin
            mem_d[wr_ptr_q] = {dividend, divisor};
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow of
    // a PW-bit counter.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        zero_cnt_d = zero_cnt_q;

        if (do_enq) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({do_enq, do_deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (do_deq && div_by_zero && (zero_cnt_q != 8'hFF)) begin
            zero_cnt_d = zero_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            zero_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end

endmodule

// File: doc/div_operand_queue.md
DIV_OPERAND_QUEUE -- requirements
Module: div_operand_queue

Interface
REQ-001 SHALL have parameter: DEPTH, default 4, number of operand-pair entries; legal values are powers of two, from 2 to 16.
REQ-002 SHALL have port: clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset_L  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  upstream presents an operand pair.
REQ-005 SHALL have port: in_ready  output  1  queue can accept a pair this cycle.
REQ-006 SHALL have port: dividend  input  2  dividend bits [1:0].
REQ-007 SHALL have port: divisor  input  2  divisor bits [1:0].
REQ-008 SHALL have port: out_valid  output  1  head entry is presented to the divider.
REQ-009 SHALL have port: out_ready  input  1  downstream consumed the divider result this cycle.
REQ-010 SHALL have port: div_a, div_b, div_c, div_d  output  1 each  operand bits to the combinational divider: a=dividend[1], b=dividend[0], c=divisor[1], d=divisor[0].
REQ-011 SHALL have port: div_by_zero  output  1  head entry has divisor 2'b00.
REQ-012 SHALL have port: count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-013 SHALL have port: zero_cnt  output  8  saturating count of dequeued zero-divisor entries.

Function
REQ-014 SHALL store each entry as 4 bits {dividend, divisor} in a circular buffer of DEPTH entries, with write and read pointers.
REQ-015 SHALL drive in_ready = (count < DEPTH), from registered state only, with no combinational path from in_valid or out_ready.
REQ-016 SHALL enqueue on the rising edge when in_valid && in_ready: write the entry at the write pointer, then advance the write pointer modulo DEPTH.
REQ-017 SHALL ignore in_valid while full: no write, no pointer change, and stored data stays intact.
REQ-018 SHALL drive out_valid = (count != 0).
REQ-019 SHALL dequeue on the rising edge when out_valid && out_ready: advance the read pointer modulo DEPTH.
REQ-020 SHALL ignore out_ready while empty: no pointer change, and count stays 0 (no underflow).
REQ-021 SHALL, on simultaneous enqueue and dequeue, perform both and leave count unchanged; when full, enqueue is blocked that cycle even though a dequeue occurs (no full pass-through).
REQ-022 SHALL make an entry enqueued at edge N visible on div_* at edge N+1, when the queue was empty (latency 1 cycle).
REQ-023 SHALL present the head entry on div_a..div_d combinationally from the storage at the read pointer while out_valid=1, and drive div_a..div_d to 0 while empty.
REQ-024 SHALL drive div_by_zero = out_valid && (head divisor == 2'b00), and deliver zero-divisor entries in order like any other entry, never dropping them.
REQ-025 SHALL increment zero_cnt by 1 on each dequeue of an entry with div_by_zero=1, saturating at 255.
REQ-026 SHALL preserve FIFO order across pointer wrap-around for an unlimited number of operations.
REQ-027 SHALL update count on every edge as +1 on enqueue only, -1 on dequeue only, and unchanged on both or neither.

Reset
REQ-028 SHALL, while reset_L=0 and independent of clock: clear both pointers, count=0, and zero_cnt=0; this gives out_valid=0, in_ready=1, div_*=0 and div_by_zero=0.
REQ-029 SHALL discard all queued entries on a reset asserted mid-operation, and SHALL accept the first enqueue on the first rising edge after reset_L rises.
REQ-030 SHALL NOT reset the storage array contents; the array is unobservable while empty.

Verification
REQ-031 SHALL cover: reset, then enqueue (dividend=2'b11, divisor=2'b10) -> next cycle out_valid=1, div_a..d=1,1,1,0, div_by_zero=0, count=1.
REQ-032 SHALL cover: DEPTH=4, enqueue 5 pairs with out_ready=0 -> count=4, in_ready=0, 5th pair lost; then drain -> pairs 1-4 emerge in order.
REQ-033 SHALL cover: queue full while in_valid=1 and out_ready=1 for 1 cycle -> count 4->3, the new pair is not taken; next cycle in_ready=1.
REQ-034 SHALL cover: enqueue divisor=2'b00 three times, then drain -> div_by_zero=1 on each at head, and zero_cnt=3; 300 such entries -> zero_cnt=255.
REQ-035 SHALL cover: 3 entries queued, reset_L pulsed low mid-cycle -> immediately count=0, out_valid=0, div_*=0; after release, one enqueue -> count=1.
REQ-036 SHALL cover: 20 random enqueue/dequeue cycles with both active -> output order matches a scoreboard across more than 4 pointer wraps.
